count_wrap_tracker: RTL and testbench

//   Sits directly downstream of the 4-bit free-running counter; samples its count every clk.

---
 rtl/cwt_pkg.sv | 13 +
 rtl/cwt_wrap_detect.sv | 29 ++
 rtl/count_wrap_tracker.sv | 112 +++++++++++
 tb/tb_count_wrap_tracker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cwt_pkg.sv
// Shared types and defaults for count_wrap_tracker.
// Optional feature macro: CWT_MISS_CNT_EN (dropped-match counter).
package cwt_pkg;
   localparam int CNT_W_DEF = 4;
   localparam int EXT_W_DEF = 8;
   localparam int MISS_W    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      PENDING = 2'd2
   } state_t;
endpackage

// File: rtl/cwt_wrap_detect.sv
// Registers the upstream count and decodes wrap (MAX->0) and resync (upstream reset) strobes.
module cwt_wrap_detect
   import cwt_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_in,
   output logic [CNT_W-1:0] count_q,
   output logic             wrap,
   output logic             resync
);
   localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

   logic in_zero;

   always_comb begin
      in_zero = (count_in == '0);
      wrap    = in_zero && (count_q == MAX);
      // A drop to zero from anywhere but MAX means the upstream counter was reset on its own
      resync  = in_zero && (count_q != '0) && (count_q != MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_in;
   end
endmodule

// File: rtl/count_wrap_tracker.sv
// Extends a free-running count with a wrap word, matches against a threshold, reports via valid/ready.
// Optional feature macro: CWT_MISS_CNT_EN adds the missed_cnt port (saturating dropped-match count).
module count_wrap_tracker
   import cwt_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int EXT_W      = EXT_W_DEF,
   parameter int AUTO_REARM = 0,
   localparam int XW        = CNT_W + EXT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_in,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [XW-1:0]    cfg_thresh,
   output logic [XW-1:0]    ext_count,
   output logic             wrap_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [XW-1:0]    evt_value
`ifdef CWT_MISS_CNT_EN
   ,
   output logic [MISS_W-1:0] missed_cnt
`endif
);
   logic [CNT_W-1:0] count_q;
   logic             wrap, resync;
   logic [EXT_W-1:0] hi_q, hi_d;
   logic [XW-1:0]    thresh_q, thresh_d;
   logic [XW-1:0]    evt_value_q, evt_value_d;
   logic [XW-1:0]    ext_next;
   logic             wrap_pulse_q;
   logic             match, cfg_fire;
   state_t           state_q, state_d;

   cwt_wrap_detect #(.CNT_W(CNT_W)) u_wrap (
      .clk      (clk),
      .rst      (rst),
      .count_in (count_in),
      .count_q  (count_q),
      .wrap     (wrap),
      .resync   (resync)
   );

   assign ext_count  = {hi_q, count_q};
   assign wrap_pulse = wrap_pulse_q;
   assign evt_valid  = (state_q == PENDING);
   assign evt_value  = evt_value_q;
   assign cfg_ready  = !rst && (state_q != PENDING);
   assign cfg_fire   = cfg_valid && cfg_ready;

   always_comb begin
      hi_d = hi_q;
      if (wrap)        hi_d = hi_q + EXT_W'(1);
      else if (resync) hi_d = '0;
      ext_next = {hi_d, count_in};
      // Only entry into equality counts, so a stalled counter cannot re-fire
      match    = (ext_next == thresh_q) && (ext_next != ext_count);
   end

   always_comb begin
      state_d     = state_q;
      thresh_d    = thresh_q;
      evt_value_d = evt_value_q;
      if (cfg_fire) thresh_d = cfg_thresh;
      case (state_q)
         IDLE:    if (cfg_fire) state_d = ARMED;
         ARMED:   if (match) begin
                     state_d     = PENDING;
                     evt_value_d = ext_next;
                  end
         PENDING: if (evt_ready) state_d = (AUTO_REARM != 0) ? ARMED : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q         <= '0;
         wrap_pulse_q <= 1'b0;
         thresh_q     <= '0;
         evt_value_q  <= '0;
         state_q      <= IDLE;
      end else begin
         hi_q         <= hi_d;
         wrap_pulse_q <= wrap;
         thresh_q     <= thresh_d;
         evt_value_q  <= evt_value_d;
         state_q      <= state_d;
      end
   end

`ifdef CWT_MISS_CNT_EN
   logic [MISS_W-1:0] missed_q, missed_d;

   always_comb begin
      missed_d = missed_q;
      if (cfg_fire)
         missed_d = '0;
      else if (match && (state_q == PENDING) && (missed_q != '1))
         missed_d = missed_q + MISS_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) missed_q <= '0;
      else     missed_q <= missed_d;
   end

   assign missed_cnt = missed_q;
`endif
endmodule

// File: tb/tb_count_wrap_tracker.sv
// Directed bench for count_wrap_tracker: vector table plus hand sequences for long corner cases.
module tb_count_wrap_tracker;
   localparam int XW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    count_in = '0;
   logic          cfg_valid = 1'b0;
   logic [XW-1:0] cfg_thresh = '0;
   logic          evt_ready = 1'b0;

   logic          cfg_ready, wrap_pulse, evt_valid;
   logic [XW-1:0] ext_count, evt_value;
   logic          os_cfg_ready, os_wrap_pulse, os_evt_valid;
   logic [XW-1:0] os_ext_count, os_evt_value;
`ifdef CWT_MISS_CNT_EN
   logic [7:0]    missed_cnt, os_missed_cnt;
`endif

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   count_wrap_tracker #(.CNT_W(4), .EXT_W(8), .AUTO_REARM(1)) dut (
      .clk(clk), .rst(rst), .count_in(count_in), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_thresh(cfg_thresh), .ext_count(ext_count), .wrap_pulse(wrap_pulse),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_value(evt_value)
`ifdef CWT_MISS_CNT_EN
      , .missed_cnt(missed_cnt)
`endif
   );

   // One-shot twin shares every input; used to tell IDLE from ARMED after an accept
   count_wrap_tracker #(.CNT_W(4), .EXT_W(8), .AUTO_REARM(0)) u_os (
      .clk(clk), .rst(rst), .count_in(count_in), .cfg_valid(cfg_valid), .cfg_ready(os_cfg_ready),
      .cfg_thresh(cfg_thresh), .ext_count(os_ext_count), .wrap_pulse(os_wrap_pulse),
      .evt_valid(os_evt_valid), .evt_ready(evt_ready), .evt_value(os_evt_value)
`ifdef CWT_MISS_CNT_EN
      , .missed_cnt(os_missed_cnt)
`endif
   );

   typedef struct {
      logic          rst;
      logic [3:0]    cnt;
      logic          cv;
      logic [XW-1:0] th;
      logic          er;
      logic [XW-1:0] ext;
      logic          wp;
      logic          ev;
      logic [XW-1:0] evv;
      logic          cr;
   } vec_t;

   vec_t vt[26];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] c, input logic cv, input logic [XW-1:0] th, input logic er);
      count_in   = c;
      cfg_valid  = cv;
      cfg_thresh = th;
      evt_ready  = er;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(4'd0, 1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      //          rst   cnt  cv  th      er   ext     wp  ev  evv     cr
      vt[0]  = '{1'b1, 4'd5,  0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0};
      vt[1]  = '{1'b0, 4'd14, 0, 12'h000, 0, 12'h00E, 0, 0, 12'h000, 1};
      vt[2]  = '{1'b0, 4'd15, 0, 12'h000, 0, 12'h00F, 0, 0, 12'h000, 1};
      vt[3]  = '{1'b0, 4'd0,  0, 12'h000, 0, 12'h010, 1, 0, 12'h000, 1};
      vt[4]  = '{1'b0, 4'd1,  0, 12'h000, 0, 12'h011, 0, 0, 12'h000, 1};
      vt[5]  = '{1'b1, 4'd2,  0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0};
      vt[6]  = '{1'b0, 4'd3,  0, 12'h000, 0, 12'h003, 0, 0, 12'h000, 1};
      vt[7]  = '{1'b0, 4'd4,  1, 12'h006, 0, 12'h004, 0, 0, 12'h000, 1};
      vt[8]  = '{1'b0, 4'd5,  0, 12'h000, 0, 12'h005, 0, 0, 12'h000, 1};
      vt[9]  = '{1'b0, 4'd6,  0, 12'h000, 0, 12'h006, 0, 1, 12'h006, 0};
      vt[10] = '{1'b0, 4'd7,  0, 12'h000, 0, 12'h007, 0, 1, 12'h006, 0};
      vt[11] = '{1'b0, 4'd8,  0, 12'h000, 1, 12'h008, 0, 0, 12'h000, 1};
      vt[12] = '{1'b0, 4'd9,  1, 12'h00A, 0, 12'h009, 0, 0, 12'h000, 1};
      vt[13] = '{1'b0, 4'd10, 1, 12'h00C, 0, 12'h00A, 0, 1, 12'h00A, 0};
      vt[14] = '{1'b0, 4'd11, 0, 12'h000, 1, 12'h00B, 0, 0, 12'h000, 1};
      vt[15] = '{1'b0, 4'd12, 0, 12'h000, 0, 12'h00C, 0, 1, 12'h00C, 0};
      vt[16] = '{1'b0, 4'd12, 0, 12'h000, 1, 12'h00C, 0, 0, 12'h000, 1};
      vt[17] = '{1'b0, 4'd12, 0, 12'h000, 0, 12'h00C, 0, 0, 12'h000, 1};
      vt[18] = '{1'b0, 4'd12, 0, 12'h000, 0, 12'h00C, 0, 0, 12'h000, 1};
      vt[19] = '{1'b0, 4'd15, 0, 12'h000, 0, 12'h00F, 0, 0, 12'h000, 1};
      vt[20] = '{1'b0, 4'd0,  0, 12'h000, 0, 12'h010, 1, 0, 12'h000, 1};
      vt[21] = '{1'b0, 4'd9,  0, 12'h000, 0, 12'h019, 0, 0, 12'h000, 1};
      vt[22] = '{1'b0, 4'd0,  0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 1};
      vt[23] = '{1'b0, 4'd12, 0, 12'h000, 0, 12'h00C, 0, 1, 12'h00C, 0};
      vt[24] = '{1'b0, 4'd12, 0, 12'h000, 1, 12'h00C, 0, 0, 12'h000, 1};
      vt[25] = '{1'b0, 4'd12, 0, 12'h000, 0, 12'h00C, 0, 0, 12'h000, 1};

      for (int i = 0; i < 26; i++) begin
         rst = vt[i].rst;
         cyc(vt[i].cnt, vt[i].cv, vt[i].th, vt[i].er);
         chk($sformatf("v%0d ext_count", i), 32'(ext_count), 32'(vt[i].ext));
         chk($sformatf("v%0d wrap_pulse", i), 32'(wrap_pulse), 32'(vt[i].wp));
         chk($sformatf("v%0d evt_valid", i), 32'(evt_valid), 32'(vt[i].ev));
         chk($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 32'(vt[i].cr));
         if (vt[i].ev || vt[i].rst)
            chk($sformatf("v%0d evt_value", i), 32'(evt_value), 32'(vt[i].evv));
      end
      rst = 1'b0;

      // Match after two wraps, then a long stall on evt_ready
      do_reset();
      cyc(4'd0, 1'b1, 12'h023, 1'b0);
      for (int n = 1; n <= 12'h022; n++) cyc(4'(n), 1'b0, '0, 1'b0);
      chk("m3 no early evt", 32'(evt_valid), 32'd0);
      cyc(4'h3, 1'b0, '0, 1'b0);
      chk("m3 evt_valid", 32'(evt_valid), 32'd1);
      chk("m3 evt_value", 32'(evt_value), 32'h023);
      chk("m3 ext_count", 32'(ext_count), 32'h023);
      for (int n = 12'h024; n < 12'h024 + 40; n++) begin
         cyc(4'(n), 1'b0, '0, 1'b0);
         chk($sformatf("hold%0d evt_valid", n), 32'(evt_valid), 32'd1);
         chk($sformatf("hold%0d evt_value", n), 32'(evt_value), 32'h023);
      end
      chk("hold cfg_ready", 32'(cfg_ready), 32'd0);

      // Auto-rearm versus one-shot across a full 12-bit roll-over
      do_reset();
      cyc(4'd0, 1'b1, 12'h005, 1'b0);
      for (int n = 1; n <= 5; n++) cyc(4'(n), 1'b0, '0, 1'b0);
      chk("h4 evt_valid", 32'(evt_valid), 32'd1);
      chk("h4 os evt_valid", 32'(os_evt_valid), 32'd1);
      cyc(4'd6, 1'b0, '0, 1'b1);
      chk("h4 accept evt_valid", 32'(evt_valid), 32'd0);
      chk("h4 accept os evt_valid", 32'(os_evt_valid), 32'd0);
      for (int n = 7; n <= 4100; n++) begin
         cyc(4'(n), 1'b0, '0, 1'b0);
         if (n == 4095) chk("h4 ext all-ones", 32'(ext_count), 32'hFFF);
         if (n == 4096) begin
            chk("h4 ext rollover", 32'(ext_count), 32'h000);
            chk("h4 rollover wrap_pulse", 32'(wrap_pulse), 32'd1);
         end
         if (n == 4100) chk("h4 no early rearm evt", 32'(evt_valid), 32'd0);
      end
      cyc(4'd5, 1'b0, '0, 1'b0);
      chk("h4 rearm evt_valid", 32'(evt_valid), 32'd1);
      chk("h4 rearm evt_value", 32'(evt_value), 32'h005);
      chk("h4 oneshot stays idle", 32'(os_evt_valid), 32'd0);
      chk("h4 oneshot cfg_ready", 32'(os_cfg_ready), 32'd1);

`ifdef CWT_MISS_CNT_EN
      // Dropped matches while pending, made cheap by resyncing the high word to 0
      do_reset();
      cyc(4'd0, 1'b1, 12'h001, 1'b0);
      cyc(4'd1, 1'b0, '0, 1'b0);
      chk("m6 evt_valid", 32'(evt_valid), 32'd1);
      chk("m6 missed start", 32'(missed_cnt), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(4'd5, 1'b0, '0, 1'b0);
         cyc(4'd0, 1'b0, '0, 1'b0);
         cyc(4'd1, 1'b0, '0, 1'b0);
      end
      chk("m6 missed_cnt", 32'(missed_cnt), 32'd3);
      chk("m6 evt_value", 32'(evt_value), 32'h001);
      cyc(4'd2, 1'b0, '0, 1'b1);
      chk("m6 missed after accept", 32'(missed_cnt), 32'd3);
      cyc(4'd3, 1'b1, 12'h0F0, 1'b0);
      chk("m6 missed cleared", 32'(missed_cnt), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
